// File: rtl/condlogic_pipe.sv
`default_nettype none
// ============================================================================
// condlogic_pipe : execute-stage NZCV flags, condition check, E->M control reg
// Revision 1.0 - initial release
// ============================================================================
module condlogic_pipe #(
    parameter int WA_W     = 4,
    parameter int CNT_W    = 16,
    parameter bit NV_NEVER = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallE,
    input  logic             FlushM,
    input  logic             PCSrcE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MemWriteE,
    input  logic             BranchE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       CondE,
    input  logic [3:0]       ALUFlags,
    input  logic [WA_W-1:0]  WA3E,
    input  logic             ValidE,
    output logic             CondExE,
    output logic             BranchTakenE,
    output logic [3:0]       FlagsE,
    output logic             PCSrcM,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             MemtoRegM,
    output logic [WA_W-1:0]  WA3M,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       flags_q, flags_d;
    logic             pcsrc_q, pcsrc_d;
    logic             regwrite_q, regwrite_d;
    logic             memwrite_q, memwrite_d;
    logic             memtoreg_q, memtoreg_d;
    logic [WA_W-1:0]  wa3_q, wa3_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    logic w_n, w_z, w_c, w_v;
    logic w_cond_ex;
    logic w_go;
    logic w_advance;

    assign {w_n, w_z, w_c, w_v} = flags_q;

    // Decoded from the registered flags, so a flag write reaches only the next instruction
    always_comb begin
        w_cond_ex = 1'b0;
        case (CondE)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = ~NV_NEVER;
        endcase
    end

    assign w_go         = w_cond_ex & ValidE;
    assign w_advance    = ~StallE & ValidE;
    assign CondExE      = w_cond_ex;
    assign BranchTakenE = BranchE & w_go;

    always_comb begin
        flags_d = flags_q;
        if (w_advance && w_cond_ex) begin
            if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // Stall wins over flush: a stalled bubble must not overwrite the held instruction
    always_comb begin
        pcsrc_d    = pcsrc_q;
        regwrite_d = regwrite_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        wa3_d      = wa3_q;
        if (!StallE) begin
            if (FlushM) begin
                pcsrc_d    = 1'b0;
                regwrite_d = 1'b0;
                memwrite_d = 1'b0;
                memtoreg_d = 1'b0;
                wa3_d      = '0;
            end else begin
                pcsrc_d    = PCSrcE & w_go;
                regwrite_d = RegWriteE & w_go;
                memwrite_d = MemWriteE & w_go;
                memtoreg_d = MemtoRegE;
                wa3_d      = WA3E;
            end
        end
    end

    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (w_advance) begin
            if (w_cond_ex) begin
                if (exec_cnt_q != c_cnt_max) exec_cnt_d = exec_cnt_q + c_cnt_one;
            end else begin
                if (squash_cnt_q != c_cnt_max) squash_cnt_d = squash_cnt_q + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q      <= '0;
            pcsrc_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            wa3_q        <= '0;
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            flags_q      <= flags_d;
            pcsrc_q      <= pcsrc_d;
            regwrite_q   <= regwrite_d;
            memwrite_q   <= memwrite_d;
            memtoreg_q   <= memtoreg_d;
            wa3_q        <= wa3_d;
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign FlagsE      = flags_q;
    assign PCSrcM      = pcsrc_q;
    assign RegWriteM   = regwrite_q;
    assign MemWriteM   = memwrite_q;
    assign MemtoRegM   = memtoreg_q;
    assign WA3M        = wa3_q;
    assign ExecCount   = exec_cnt_q;
    assign SquashCount = squash_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_condlogic_pipe.sv
`default_nettype none
// Directed table-driven bench for condlogic_pipe; a second instance covers NV_NEVER=0, CNT_W=4.
module tb_condlogic_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       StallE, FlushM, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ValidE;
    logic [1:0] FlagWriteE;
    logic [3:0] CondE, ALUFlags, WA3E;

    logic        a_condex, a_bt, a_pcsm, a_rwm, a_mwm, a_m2rm;
    logic [3:0]  a_flags, a_wa3m;
    logic [15:0] a_exec, a_squash;

    logic        b_condex, b_bt, b_pcsm, b_rwm, b_mwm, b_m2rm;
    logic [3:0]  b_flags, b_wa3m;
    logic [3:0]  b_exec, b_squash;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    condlogic_pipe #(.WA_W(4), .CNT_W(16), .NV_NEVER(1'b1)) u_a (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushM(FlushM), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .FlagWriteE(FlagWriteE), .CondE(CondE), .ALUFlags(ALUFlags), .WA3E(WA3E), .ValidE(ValidE),
        .CondExE(a_condex), .BranchTakenE(a_bt), .FlagsE(a_flags), .PCSrcM(a_pcsm),
        .RegWriteM(a_rwm), .MemWriteM(a_mwm), .MemtoRegM(a_m2rm), .WA3M(a_wa3m),
        .ExecCount(a_exec), .SquashCount(a_squash)
    );

    condlogic_pipe #(.WA_W(4), .CNT_W(4), .NV_NEVER(1'b0)) u_b (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushM(FlushM), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .FlagWriteE(FlagWriteE), .CondE(CondE), .ALUFlags(ALUFlags), .WA3E(WA3E), .ValidE(ValidE),
        .CondExE(b_condex), .BranchTakenE(b_bt), .FlagsE(b_flags), .PCSrcM(b_pcsm),
        .RegWriteM(b_rwm), .MemWriteM(b_mwm), .MemtoRegM(b_m2rm), .WA3M(b_wa3m),
        .ExecCount(b_exec), .SquashCount(b_squash)
    );

    typedef struct {
        logic       stall, flush, valid;
        logic [3:0] cond;
        logic [1:0] fw;
        logic [3:0] alu;
        logic       pcs, rw, mw, m2r, br;
        logic [3:0] wa;
        logic       x_condex, x_bt;
        logic [3:0] x_flags;
        logic       x_pcs, x_rw, x_mw, x_m2r;
        logic [3:0] x_wa;
        int         x_exec, x_squash;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(
        input logic st, input logic fl, input logic va, input logic [3:0] cd, input logic [1:0] fw,
        input logic [3:0] alu, input logic pcs, input logic rw, input logic mw, input logic m2r,
        input logic br, input logic [3:0] wa,
        input logic xc, input logic xb, input logic [3:0] xf, input logic xp, input logic xr,
        input logic xm, input logic xm2r, input logic [3:0] xw, input int xe, input int xs);
        vec_t v;
        v.stall = st; v.flush = fl; v.valid = va; v.cond = cd; v.fw = fw; v.alu = alu;
        v.pcs = pcs; v.rw = rw; v.mw = mw; v.m2r = m2r; v.br = br; v.wa = wa;
        v.x_condex = xc; v.x_bt = xb; v.x_flags = xf; v.x_pcs = xp; v.x_rw = xr;
        v.x_mw = xm; v.x_m2r = xm2r; v.x_wa = xw; v.x_exec = xe; v.x_squash = xs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic va, input logic [3:0] cd,
                         input logic [1:0] fw, input logic [3:0] alu, input logic pcs,
                         input logic rw, input logic mw, input logic m2r, input logic br,
                         input logic [3:0] wa);
        StallE = st; FlushM = fl; ValidE = va; CondE = cd; FlagWriteE = fw; ALUFlags = alu;
        PCSrcE = pcs; RegWriteE = rw; MemWriteE = mw; MemtoRegE = m2r; BranchE = br; WA3E = wa;
    endtask

    task automatic check_m(input string tag, input logic p, input logic r, input logic m,
                           input logic m2r, input logic [3:0] wa);
        check({tag, ".PCSrcM"},    {31'd0, a_pcsm}, {31'd0, p});
        check({tag, ".RegWriteM"}, {31'd0, a_rwm},  {31'd0, r});
        check({tag, ".MemWriteM"}, {31'd0, a_mwm},  {31'd0, m});
        check({tag, ".MemtoRegM"}, {31'd0, a_m2rm}, {31'd0, m2r});
        check({tag, ".WA3M"},      {28'd0, a_wa3m}, {28'd0, wa});
    endtask

    initial begin
        // Flags {N,Z,C,V}; expected values worked by hand from the ARM condition table.
        //               st fl va cond   fw     alu    pc rw mw m2 br wa   | cx bt flags  pc rw mw m2 wa   ex sq
        vecs[0]  = mk(0, 0, 1, 4'hE, 2'b11, 4'b0110, 0, 1, 0, 0, 0, 4'h3, 1, 0, 4'b0110, 0, 1, 0, 0, 4'h3, 1, 0);
        vecs[1]  = mk(0, 0, 1, 4'h1, 2'b11, 4'b1111, 0, 1, 1, 1, 0, 4'h5, 0, 0, 4'b0110, 0, 0, 0, 1, 4'h5, 1, 1);
        vecs[2]  = mk(0, 0, 1, 4'h0, 2'b11, 4'b1000, 1, 0, 0, 0, 1, 4'h7, 1, 1, 4'b1000, 1, 0, 0, 0, 4'h7, 2, 1);
        vecs[3]  = mk(0, 0, 1, 4'hB, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 4'h1, 1, 0, 4'b1000, 0, 1, 0, 0, 4'h1, 3, 1);
        vecs[4]  = mk(0, 0, 1, 4'hA, 2'b00, 4'b0000, 0, 0, 1, 0, 0, 4'h2, 0, 0, 4'b1000, 0, 0, 0, 0, 4'h2, 3, 2);
        vecs[5]  = mk(0, 0, 1, 4'hC, 2'b01, 4'b1111, 0, 0, 0, 0, 0, 4'h0, 0, 0, 4'b1000, 0, 0, 0, 0, 4'h0, 3, 3);
        vecs[6]  = mk(0, 0, 1, 4'hE, 2'b01, 4'b1111, 0, 0, 1, 0, 0, 4'h4, 1, 0, 4'b1011, 0, 0, 1, 0, 4'h4, 4, 3);
        vecs[7]  = mk(0, 0, 1, 4'h8, 2'b10, 4'b0100, 0, 1, 0, 0, 0, 4'h6, 1, 0, 4'b0111, 0, 1, 0, 0, 4'h6, 5, 3);
        vecs[8]  = mk(0, 0, 0, 4'h9, 2'b11, 4'b0000, 0, 1, 0, 1, 1, 4'h9, 1, 0, 4'b0111, 0, 0, 0, 1, 4'h9, 5, 3);
        vecs[9]  = mk(0, 0, 1, 4'h6, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 4'h2, 1, 0, 4'b0111, 0, 0, 0, 0, 4'h2, 6, 3);
        vecs[10] = mk(0, 0, 1, 4'h4, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 4'h3, 0, 0, 4'b0111, 0, 0, 0, 0, 4'h3, 6, 4);
        vecs[11] = mk(0, 0, 1, 4'h5, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 4'h4, 1, 0, 4'b0111, 0, 0, 0, 0, 4'h4, 7, 4);
        vecs[12] = mk(0, 0, 1, 4'h3, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 4'h5, 0, 0, 4'b0111, 0, 0, 0, 0, 4'h5, 7, 5);
        vecs[13] = mk(0, 0, 1, 4'h7, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 4'h6, 0, 0, 4'b0111, 0, 0, 0, 0, 4'h6, 7, 6);
        vecs[14] = mk(0, 0, 1, 4'h2, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 4'h7, 1, 0, 4'b0111, 0, 0, 0, 0, 4'h7, 8, 6);
        vecs[15] = mk(0, 0, 1, 4'hD, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 4'h8, 1, 0, 4'b0111, 0, 1, 0, 0, 4'h8, 9, 6);
        vecs[16] = mk(0, 0, 1, 4'hC, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 4'h9, 0, 0, 4'b0111, 0, 0, 0, 0, 4'h9, 9, 7);
        vecs[17] = mk(0, 1, 1, 4'hE, 2'b11, 4'b0000, 1, 1, 1, 1, 1, 4'hF, 1, 1, 4'b0000, 0, 0, 0, 0, 4'h0, 10, 7);

        reset = 1'b1;
        drive(0, 0, 0, 4'h0, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.FlagsE", {28'd0, a_flags}, 32'h0);
        check_m("reset", 0, 0, 0, 0, 4'h0);
        check("reset.ExecCount",   {16'd0, a_exec},   32'd0);
        check("reset.SquashCount", {16'd0, a_squash}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].cond, vecs[i].fw,
                  vecs[i].alu, vecs[i].pcs, vecs[i].rw, vecs[i].mw, vecs[i].m2r, vecs[i].br,
                  vecs[i].wa);
            #1;
            check($sformatf("v%0d.CondExE", i),      {31'd0, a_condex}, {31'd0, vecs[i].x_condex});
            check($sformatf("v%0d.BranchTakenE", i), {31'd0, a_bt},     {31'd0, vecs[i].x_bt});
            @(posedge clk);
            #1;
            check($sformatf("v%0d.FlagsE", i), {28'd0, a_flags}, {28'd0, vecs[i].x_flags});
            check_m($sformatf("v%0d", i), vecs[i].x_pcs, vecs[i].x_rw, vecs[i].x_mw,
                    vecs[i].x_m2r, vecs[i].x_wa);
            check($sformatf("v%0d.ExecCount", i),   {16'd0, a_exec},   vecs[i].x_exec);
            check($sformatf("v%0d.SquashCount", i), {16'd0, a_squash}, vecs[i].x_squash);
        end

        // CondE=1111: never on instance A, always on instance B
        @(negedge clk);
        drive(0, 0, 1, 4'hF, 2'b00, 4'b0000, 0, 1, 0, 1, 1, 4'hF);
        #1;
        check("nv.A.CondExE",      {31'd0, a_condex}, 32'd0);
        check("nv.A.BranchTakenE", {31'd0, a_bt},     32'd0);
        check("nv.B.BranchTakenE", {31'd0, b_bt},     32'd1);
        @(posedge clk);
        #1;
        check_m("nv.A", 0, 0, 0, 1, 4'hF);
        check("nv.A.SquashCount", {16'd0, a_squash}, 32'd8);
        check("nv.B.RegWriteM",   {31'd0, b_rwm},    32'd1);

        @(negedge clk);
        drive(0, 0, 1, 4'hE, 2'b00, 4'b0000, 1, 1, 1, 1, 0, 4'hA);
        @(posedge clk);
        #1;
        check_m("prestall", 1, 1, 1, 1, 4'hA);
        check("prestall.ExecCount", {16'd0, a_exec}, 32'd11);

        // Stall with flush and fresh inputs must freeze everything
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1, 1, 1, 4'hE, 2'b11, 4'b1111, 0, 0, 0, 0, 1, 4'h3 + 4'(c));
            @(posedge clk);
            #1;
            check($sformatf("stall%0d.FlagsE", c), {28'd0, a_flags}, 32'h0);
            check_m($sformatf("stall%0d", c), 1, 1, 1, 1, 4'hA);
            check($sformatf("stall%0d.ExecCount", c),   {16'd0, a_exec},   32'd11);
            check($sformatf("stall%0d.SquashCount", c), {16'd0, a_squash}, 32'd8);
        end

        @(negedge clk);
        drive(0, 1, 1, 4'hE, 2'b00, 4'b0000, 1, 1, 1, 1, 0, 4'h6);
        @(posedge clk);
        #1;
        check_m("release_flush", 0, 0, 0, 0, 4'h0);
        check("release_flush.ExecCount", {16'd0, a_exec}, 32'd12);

        // Saturation on the 4-bit counters of instance B
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 4'h0, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(0, 0, 1, 4'hE, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 4'h5);
            @(posedge clk);
        end
        #1;
        check("sat.B.ExecCount",   {28'd0, b_exec},   32'd15);
        check("sat.B.SquashCount", {28'd0, b_squash}, 32'd0);
        check("sat.A.ExecCount",   {16'd0, a_exec},   32'd20);
        check("sat.A.FlagsE",      {28'd0, a_flags},  32'hF);
        check_m("sat.A", 0, 1, 0, 0, 4'h5);

        // Asynchronous reset mid-cycle while stalled
        @(negedge clk);
        drive(1, 0, 1, 4'hE, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 4'h5);
        #2;
        reset = 1'b1;
        #1;
        check("areset.FlagsE", {28'd0, a_flags}, 32'h0);
        check_m("areset", 0, 0, 0, 0, 4'h0);
        check("areset.A.ExecCount", {16'd0, a_exec}, 32'd0);
        check("areset.B.ExecCount", {28'd0, b_exec}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
